// File: rtl/mojo_audio_pkg.sv
// Shared audio definitions: default sample width, slot size and the
// receiver frame-alignment state type.
package mojo_audio_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int SLOT_MAX_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_t;

endpackage

// File: rtl/adc_sync2.sv
// Two-flop synchronizer for W asynchronous inputs. Bit 0 additionally gets
// a registered rising-edge pulse (one clk wide) taken from its synchronized copy.
module adc_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         rise
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;
    logic         prev_r;
    logic         rise_r;

    // Metastability chain plus edge detector on bit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
            prev_r <= 1'b0;
            rise_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r[0];
            rise_r <= sync_r[0] & ~prev_r;
        end
    end

    assign q    = sync_r;
    assign rise = rise_r;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: oversamples BCK/LRCK/ADATA, deserializes MSB-first words
// into left-aligned SAMPLE_W samples and hands out L/R pairs on valid/ready.
// Optional macro I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing
// (MSB on the boundary BCK) instead of standard I2S (MSB one BCK later).
module i2s_adc_rx
    import mojo_audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int SLOT_MAX = SLOT_MAX_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_adc_adata,
    input  logic                i_adc_bck,
    input  logic                i_adc_lrck,
    output logic [SAMPLE_W-1:0] o_left,
    output logic [SAMPLE_W-1:0] o_right,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overrun,
    output logic                o_locked
);

    localparam int CNT_W = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_MAX - 1);

    // Place one serial bit at its left-aligned position for bit index idx.
    function automatic logic [SAMPLE_W-1:0] place_bit(input logic b, input logic [CNT_W-1:0] idx);
        logic [SAMPLE_W-1:0] one_s;
        one_s = {{(SAMPLE_W-1){1'b0}}, b};
        return one_s << (SAMPLE_W - 1 - int'(idx));
    endfunction

    logic [2:0]          sync_q_s;
    logic                bck_rise_s;
    logic                lrck_s;
    logic                adata_s;
    logic                boundary_s;
    logic                in_window_s;
    logic                lr_prev_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nxt_s;
    logic [SAMPLE_W-1:0] shreg_r;
    logic [SAMPLE_W-1:0] shreg_nxt_s;
    logic [SAMPLE_W-1:0] left_hold_r;
    i2s_rx_state_t       state_r;
    i2s_rx_state_t       state_nxt_s;
    logic                latch_left_s;
    logic                emit_s;
    logic [SAMPLE_W-1:0] left_r;
    logic [SAMPLE_W-1:0] right_r;
    logic                valid_r;
    logic                overrun_r;
    logic                locked_r;

    // BCK on bit 0 so its edge pulse is produced; LRCK/ADATA ride the same chain.
    adc_sync2 #(.W(3)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({i_adc_adata, i_adc_lrck, i_adc_bck}),
        .q     (sync_q_s),
        .rise  (bck_rise_s)
    );

    assign lrck_s      = sync_q_s[1];
    assign adata_s     = sync_q_s[2];
    assign boundary_s  = bck_rise_s && (lrck_s != lr_prev_r);
    assign in_window_s = (int'(cnt_r) < SAMPLE_W);

    // Bit counter and shift register update for the current BCK edge.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        shreg_nxt_s = shreg_r;
        if (bck_rise_s) begin
            if (boundary_s) begin
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
                shreg_nxt_s = place_bit(adata_s, {CNT_W{1'b0}});
                cnt_nxt_s   = CNT_W'(1);
`else
                shreg_nxt_s = {SAMPLE_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
`endif
            end else begin
                if (in_window_s) begin
                    shreg_nxt_s = shreg_r | place_bit(adata_s, cnt_r);
                end else begin
                    shreg_nxt_s = shreg_r;
                end
                if (cnt_r != CNT_SAT) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
        end else begin
            cnt_nxt_s   = cnt_r;
            shreg_nxt_s = shreg_r;
        end
    end

    // Capture-side state: counter, shift register, last LRCK level, left hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            shreg_r     <= {SAMPLE_W{1'b0}};
            lr_prev_r   <= 1'b0;
            left_hold_r <= {SAMPLE_W{1'b0}};
        end else begin
            cnt_r   <= cnt_nxt_s;
            shreg_r <= shreg_nxt_s;
            if (bck_rise_s) begin
                lr_prev_r <= lrck_s;
            end else begin
                lr_prev_r <= lr_prev_r;
            end
            if (latch_left_s) begin
                left_hold_r <= shreg_r;
            end else begin
                left_hold_r <= left_hold_r;
            end
        end
    end

    // Frame-alignment state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Alignment next-state: lock on falling LRCK, latch left on rising, emit on falling.
    always_comb begin
        state_nxt_s  = state_r;
        latch_left_s = 1'b0;
        emit_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (boundary_s && !lrck_s) begin
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LEFT: begin
                if (boundary_s && lrck_s) begin
                    latch_left_s = 1'b1;
                    state_nxt_s  = RIGHT;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            RIGHT: begin
                if (boundary_s && !lrck_s) begin
                    emit_s      = 1'b1;
                    state_nxt_s = LEFT;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output pair register with drop-on-full overrun and lock indication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            left_r    <= {SAMPLE_W{1'b0}};
            right_r   <= {SAMPLE_W{1'b0}};
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            if (emit_s) begin
                if (!valid_r || i_ready) begin
                    left_r  <= left_hold_r;
                    right_r <= shreg_r;
                    valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (i_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            locked_r <= (state_nxt_s != IDLE);
        end
    end

    assign o_left    = left_r;
    assign o_right   = right_r;
    assign o_valid   = valid_r;
    assign o_overrun = overrun_r;
    assign o_locked  = locked_r;

endmodule
